// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the multi-channel pulse generator.
// The config struct carries a fixed-width divide field; channels size-cast into their own CW.
package pulse_gen_pkg;

    typedef enum logic {
        TOGGLE = 1'b0,
        STROBE = 1'b1
    } mode_e;

    localparam int DIV_RST_DEF = 1;

    // Widest supported counter; channels with CW < CW_MAX keep the upper div bits at zero.
    localparam int CW_MAX = 32;

    typedef struct packed {
        logic [CW_MAX-1:0] div;
        mode_e             mode;
    } chan_cfg_t;

endpackage

// File: rtl/pulse_gen_multi_ch_chan.sv
// One divider channel: counter, equality compare against div, and registered pulse/wrap.
// A load (config write) or clr (sync) restarts the channel from count 0 with pulse low.
module pulse_chan
    import pulse_gen_pkg::*;
#(
    parameter int CW      = 8,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      load,
    input  logic      clr,
    input  chan_cfg_t cfg_i,
    output logic      pulse,
    output logic      wrap
);

    chan_cfg_t     cfg_q, cfg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;
    logic          wrap_q, wrap_d;
    logic          hit;

    // Equality only: any write clears count, so count can never pass div.
    assign hit = en && (CW_MAX'(cnt_q) == cfg_q.div);

    always_comb begin
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        wrap_d  = 1'b0;
        if (load || clr) begin
            if (load) cfg_d = cfg_i;
            cnt_d   = '0;
            pulse_d = 1'b0;
        end else if (en) begin
            if (hit) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            if (cfg_q.mode == TOGGLE) pulse_d = pulse_q ^ hit;
            else                      pulse_d = hit;
        end else begin
            // Disabled: a square wave freezes at its level, a strobe goes quiet.
            if (cfg_q.mode == STROBE) pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q   <= '{div: CW_MAX'(DIV_RST), mode: TOGGLE};
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            wrap_q  <= wrap_d;
        end
    end

    assign pulse = pulse_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/pulse_gen_multi_ch.sv
// Multi-channel programmable clock divider / strobe generator.
// Decodes the config port into per-channel load strobes and fans sync out to every channel.
module pulse_gen_multi_ch
    import pulse_gen_pkg::*;
#(
    parameter int CH      = 4,
    parameter int CW      = 8,
    parameter int DIV_RST = DIV_RST_DEF,
    localparam int CHW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic           cfg_mode,
    input  logic [CH-1:0]  enable,
    input  logic           sync,
    output logic [CH-1:0]  pulse,
    output logic [CH-1:0]  wrap
);

    chan_cfg_t     cfg_bus;
    logic [CH-1:0] load;

    always_comb begin
        cfg_bus.div  = CW_MAX'(cfg_div);
        cfg_bus.mode = mode_e'(cfg_mode);
    end

    // Channel indices >= CH never match, so out-of-range writes fall on the floor.
    always_comb begin
        load = '0;
        for (int i = 0; i < CH; i++) begin
            load[i] = cfg_we && (32'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        pulse_chan #(
            .CW      (CW),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (enable[g]),
            .load  (load[g]),
            .clr   (sync),
            .cfg_i (cfg_bus),
            .pulse (pulse[g]),
            .wrap  (wrap[g])
        );
    end

endmodule

// File: tb/tb_pulse_gen_multi_ch.sv
// Directed checks of the multi-channel pulse generator plus a random stream against a small model.
module tb_pulse_gen_multi_ch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_mode;
    logic [3:0] enable;
    logic       sync;
    logic [3:0] pulse, wrap;

    // Second instance with CH=3 so an out-of-range channel index is encodable.
    logic       cfg_we3;
    logic [1:0] cfg_ch3;
    logic [2:0] enable3;
    logic       sync3;
    logic [2:0] pulse3, wrap3;

    int total = 0;
    int bad   = 0;
    int edge_k;

    int   m_cnt [4];
    int   m_div [4];
    logic m_mode[4];
    logic m_p   [4];
    logic m_w   [4];

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_k <= 0;
        else        edge_k <= edge_k + 1;
    end

    pulse_gen_multi_ch #(.CH(4), .CW(8), .DIV_RST(1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_mode(cfg_mode), .enable(enable), .sync(sync), .pulse(pulse), .wrap(wrap)
    );

    pulse_gen_multi_ch #(.CH(3), .CW(8), .DIV_RST(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div),
        .cfg_mode(cfg_mode), .enable(enable3), .sync(sync3), .pulse(pulse3), .wrap(wrap3)
    );

    // Inputs change on the falling edge; outputs are read on the falling edge after each rise.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_cfg(input int ch, input int d, input logic m);
        cfg_we   = 1'b1;
        cfg_ch   = ch[1:0];
        cfg_div  = d[7:0];
        cfg_mode = m;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic sync_tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] ep, ew;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        enable = 4'hF; sync = 1'b0;
        cfg_we3 = 1'b0; cfg_ch3 = '0; enable3 = 3'h7; sync3 = 1'b0;
        repeat (2) tick();
        total++;
        if (pulse !== 4'h0 || wrap !== 4'h0) begin
            bad++; $display("FAIL reset_outputs: pulse=%h wrap=%h want 0/0", pulse, wrap);
        end
        total++;
        if (pulse3 !== 3'h0 || wrap3 !== 3'h0) begin
            bad++; $display("FAIL reset_outputs3: pulse=%h wrap=%h want 0/0", pulse3, wrap3);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            ep = ((k % 4) >= 2) ? 4'hF : 4'h0;
            ew = ((k % 2) == 0) ? 4'hF : 4'h0;
            total++;
            if (pulse !== ep || wrap !== ew) begin
                bad++; $display("FAIL reset_default edge %0d: pulse=%h wrap=%h want %h/%h", k, pulse, wrap, ep, ew);
            end
        end
    endtask

    task automatic test_mixed();
        logic [3:0] ep, ew;
        write_cfg(0, 0, 1'b0);
        write_cfg(1, 2, 1'b1);
        write_cfg(2, 255, 1'b0);
        sync_tick();
        total++;
        if (pulse !== 4'h0 || wrap !== 4'h0) begin
            bad++; $display("FAIL mixed_sync_clear: pulse=%h wrap=%h want 0/0", pulse, wrap);
        end
        for (int j = 1; j <= 520; j++) begin
            tick();
            ep[0] = (j % 2) == 1;          ew[0] = 1'b1;
            ep[1] = (j % 3) == 0;          ew[1] = (j % 3) == 0;
            ep[2] = ((j / 256) % 2) == 1;  ew[2] = (j % 256) == 0;
            ep[3] = (j % 4) >= 2;          ew[3] = (j % 2) == 0;
            total++;
            if (pulse !== ep || wrap !== ew) begin
                bad++; $display("FAIL mixed j=%0d: pulse=%h wrap=%h want %h/%h", j, pulse, wrap, ep, ew);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic ep, ew;
        write_cfg(1, 3, 1'b0);
        sync_tick();
        for (int j = 1; j <= 18; j++) begin
            enable[1] = !(j >= 7 && j <= 11);
            tick();
            ep = (j >= 4 && j <= 12) || (j >= 17);
            ew = (j == 4) || (j == 13) || (j == 17);
            total++;
            if (pulse[1] !== ep || wrap[1] !== ew) begin
                bad++; $display("FAIL gate_toggle j=%0d: pulse=%b wrap=%b want %b/%b", j, pulse[1], wrap[1], ep, ew);
            end
        end
        write_cfg(1, 2, 1'b1);
        sync_tick();
        for (int j = 1; j <= 13; j++) begin
            enable[1] = !(j >= 5 && j <= 7);
            tick();
            ep = (j == 3) || (j == 9) || (j == 12);
            total++;
            if (pulse[1] !== ep || wrap[1] !== ep) begin
                bad++; $display("FAIL gate_strobe j=%0d: pulse=%b wrap=%b want %b/%b", j, pulse[1], wrap[1], ep, ep);
            end
        end
        enable = 4'hF;
    endtask

    task automatic test_sync_write();
        logic [3:0] ep, ew;
        repeat (5) tick();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5; cfg_mode = 1'b0; sync = 1'b1;
        tick();
        cfg_we = 1'b0; sync = 1'b0;
        total++;
        if (pulse !== 4'h0 || wrap !== 4'h0) begin
            bad++; $display("FAIL sync_write_clear: pulse=%h wrap=%h want 0/0", pulse, wrap);
        end
        for (int j = 1; j <= 8; j++) begin
            tick();
            ep[0] = (j % 2) == 1;  ew[0] = 1'b1;
            ep[1] = (j % 3) == 0;  ew[1] = (j % 3) == 0;
            ep[2] = 1'b0;          ew[2] = 1'b0;
            ep[3] = j >= 6;        ew[3] = j == 6;
            total++;
            if (pulse !== ep || wrap !== ew) begin
                bad++; $display("FAIL sync_write j=%0d: pulse=%h wrap=%h want %h/%h", j, pulse, wrap, ep, ew);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] ep, ew;
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div = 8'd0; cfg_mode = 1'b1;
        tick();
        cfg_we3 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            ep = ((edge_k % 4) >= 2) ? 3'h7 : 3'h0;
            ew = ((edge_k % 2) == 0) ? 3'h7 : 3'h0;
            total++;
            if (pulse3 !== ep || wrap3 !== ew) begin
                bad++; $display("FAIL oob_write edge %0d: pulse=%h wrap=%h want %h/%h", edge_k, pulse3, wrap3, ep, ew);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] ep, ew;
        sync_tick();
        tick();
        total++;
        if (pulse[0] !== 1'b1 || wrap[0] !== 1'b1) begin
            bad++; $display("FAIL pre_reset_high: pulse0=%b wrap0=%b want 1/1", pulse[0], wrap[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (pulse !== 4'h0 || wrap !== 4'h0 || pulse3 !== 3'h0 || wrap3 !== 3'h0) begin
            bad++; $display("FAIL async_reset_clear: pulse=%h wrap=%h pulse3=%h wrap3=%h want 0", pulse, wrap, pulse3, wrap3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            ep = ((k % 4) >= 2) ? 4'hF : 4'h0;
            ew = ((k % 2) == 0) ? 4'hF : 4'h0;
            total++;
            if (pulse !== ep || wrap !== ew) begin
                bad++; $display("FAIL post_reset_div edge %0d: pulse=%h wrap=%h want %h/%h", k, pulse, wrap, ep, ew);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ep, ew;
        logic       ld;
        rst_n = 1'b0; cfg_we = 1'b0; sync = 1'b0; enable = 4'hF;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_div[i] = 1; m_mode[i] = 1'b0; m_p[i] = 1'b0; m_w[i] = 1'b0;
        end
        for (int n = 0; n < 2000; n++) begin
            cfg_we   = ($urandom_range(7) == 0);
            cfg_ch   = 2'($urandom_range(3));
            cfg_div  = ($urandom_range(15) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(5));
            cfg_mode = 1'($urandom_range(1));
            sync     = ($urandom_range(31) == 0);
            if ($urandom_range(7) == 0) enable = 4'($urandom_range(15));
            for (int i = 0; i < 4; i++) begin
                ld = cfg_we && (int'(cfg_ch) == i);
                if (ld || sync) begin
                    if (ld) begin m_div[i] = int'(cfg_div); m_mode[i] = cfg_mode; end
                    m_cnt[i] = 0; m_p[i] = 1'b0; m_w[i] = 1'b0;
                end else if (enable[i]) begin
                    if (m_cnt[i] == m_div[i]) begin
                        m_cnt[i] = 0; m_w[i] = 1'b1;
                        m_p[i] = m_mode[i] ? 1'b1 : !m_p[i];
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1; m_w[i] = 1'b0;
                        if (m_mode[i]) m_p[i] = 1'b0;
                    end
                end else begin
                    m_w[i] = 1'b0;
                    if (m_mode[i]) m_p[i] = 1'b0;
                end
                ep[i] = m_p[i];
                ew[i] = m_w[i];
            end
            tick();
            total++;
            if (pulse !== ep || wrap !== ew) begin
                bad++; $display("FAIL random cycle %0d: pulse=%h wrap=%h want %h/%h", n, pulse, wrap, ep, ew);
            end
        end
        cfg_we = 1'b0; sync = 1'b0; enable = 4'hF;
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_enable_gating();
        test_sync_write();
        test_out_of_range();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
